alu_decode_stage: RTL and testbench

Registered RV32I integer decode stage that sits in front of `ALU_32bits`. It translates a 32-bit instruction word into the 6-bit ALU operator encoding, register indices, an immediate and control flags. Instructions are accepted and delivered over valid/ready handshakes through a single output register, and the block keeps a saturating count of illegal instructions.

---
 rtl/alu_decode_stage.sv | 204 ++++++++++++++++++++
 tb/tb_alu_decode_stage.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_stage.sv
// RV32I integer decode stage feeding the 32-bit ALU: OP, OP-IMM and BRANCH to an ALU bundle.
// Latency: 1 cycle from accept to a valid bundle; one instruction per cycle when the downstream drains every cycle.
// Backpressure: instr_ready_o = !out_valid_o || out_ready_i; the bundle holds stable while it is stalled.
module alu_decode_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      instr_i,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [5:0]       alu_op_o,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o,
  output logic [4:0]       rd_o,
  output logic [31:0]      imm_o,
  output logic             src_b_imm_o,
  output logic             use_flag_o,
  output logic             branch_o,
  output logic             wb_en_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  localparam logic [5:0] OP_ADD = 6'b011000;
  localparam logic [5:0] OP_SUB = 6'b011001;
  localparam logic [5:0] OP_XOR = 6'b101111;
  localparam logic [5:0] OP_OR  = 6'b101110;
  localparam logic [5:0] OP_AND = 6'b010101;
  localparam logic [5:0] OP_SRA = 6'b100100;
  localparam logic [5:0] OP_SRL = 6'b100101;
  localparam logic [5:0] OP_SLL = 6'b100111;
  localparam logic [5:0] OP_LTS = 6'b000000;
  localparam logic [5:0] OP_LTU = 6'b000001;
  localparam logic [5:0] OP_GES = 6'b001010;
  localparam logic [5:0] OP_GEU = 6'b001011;
  localparam logic [5:0] OP_EQ  = 6'b001100;
  localparam logic [5:0] OP_NE  = 6'b001101;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i_type;
  logic [31:0] imm_b_type;
  logic [31:0] imm_shamt;

  assign opcode     = instr_i[6:0];
  assign funct3     = instr_i[14:12];
  assign funct7     = instr_i[31:25];
  assign imm_i_type = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_b_type = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_shamt  = {27'b0, instr_i[24:20]};

  logic [5:0]  d_alu_op;
  logic [31:0] d_imm;
  logic        d_src_b_imm;
  logic        d_use_flag;
  logic        d_branch;
  logic        d_wb_en;
  logic        d_legal;

  // Decode the presented instruction; any unmatched pattern falls through to the illegal bundle.
  always_comb begin
    d_alu_op    = OP_ADD;
    d_imm       = 32'b0;
    d_src_b_imm = 1'b0;
    d_use_flag  = 1'b0;
    d_branch    = 1'b0;
    d_wb_en     = 1'b0;
    d_legal     = 1'b0;

    case (opcode)
      OPC_OP: begin
        d_legal = 1'b1;
        d_wb_en = 1'b1;
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000: d_alu_op = OP_ADD;
            3'b001: d_alu_op = OP_SLL;
            3'b010: begin d_alu_op = OP_LTS; d_use_flag = 1'b1; end
            3'b011: begin d_alu_op = OP_LTU; d_use_flag = 1'b1; end
            3'b100: d_alu_op = OP_XOR;
            3'b101: d_alu_op = OP_SRL;
            3'b110: d_alu_op = OP_OR;
            default: d_alu_op = OP_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          d_alu_op = OP_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          d_alu_op = OP_SRA;
        end else begin
          d_legal = 1'b0;
        end
      end

      OPC_OP_IMM: begin
        d_legal     = 1'b1;
        d_wb_en     = 1'b1;
        d_src_b_imm = 1'b1;
        d_imm       = imm_i_type;
        case (funct3)
          3'b000: d_alu_op = OP_ADD;
          3'b001: begin
            d_alu_op = OP_SLL;
            d_imm    = imm_shamt;
            d_legal  = (funct7 == F7_BASE);
          end
          3'b010: begin d_alu_op = OP_LTS; d_use_flag = 1'b1; end
          3'b011: begin d_alu_op = OP_LTU; d_use_flag = 1'b1; end
          3'b100: d_alu_op = OP_XOR;
          3'b101: begin
            d_imm    = imm_shamt;
            d_alu_op = (funct7 == F7_ALT) ? OP_SRA : OP_SRL;
            d_legal  = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
          3'b110: d_alu_op = OP_OR;
          default: d_alu_op = OP_AND;
        endcase
      end

      OPC_BRANCH: begin
        d_legal  = 1'b1;
        d_branch = 1'b1;
        d_imm    = imm_b_type;
        case (funct3)
          3'b000: d_alu_op = OP_EQ;
          3'b001: d_alu_op = OP_NE;
          3'b100: d_alu_op = OP_LTS;
          3'b101: d_alu_op = OP_GES;
          3'b110: d_alu_op = OP_LTU;
          3'b111: d_alu_op = OP_GEU;
          default: d_legal = 1'b0;
        endcase
      end

      default: d_legal = 1'b0;
    endcase

    // Illegal instructions present a neutral ADD bundle with every side effect disabled.
    if (!d_legal) begin
      d_alu_op    = OP_ADD;
      d_imm       = 32'b0;
      d_src_b_imm = 1'b0;
      d_use_flag  = 1'b0;
      d_branch    = 1'b0;
      d_wb_en     = 1'b0;
    end
  end

  logic accept;

  assign instr_ready_o = !rst_i && (!out_valid_o || out_ready_i);
  assign accept        = instr_valid_i && instr_ready_o;

  // Output register: load on accept, drop valid on a drain without a replacement.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      alu_op_o    <= 6'b0;
      rs1_o       <= 5'b0;
      rs2_o       <= 5'b0;
      rd_o        <= 5'b0;
      imm_o       <= 32'b0;
      src_b_imm_o <= 1'b0;
      use_flag_o  <= 1'b0;
      branch_o    <= 1'b0;
      wb_en_o     <= 1'b0;
      illegal_o   <= 1'b0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      alu_op_o    <= d_alu_op;
      rs1_o       <= instr_i[19:15];
      rs2_o       <= instr_i[24:20];
      rd_o        <= instr_i[11:7];
      imm_o       <= d_imm;
      src_b_imm_o <= d_src_b_imm;
      use_flag_o  <= d_use_flag;
      branch_o    <= d_branch;
      wb_en_o     <= d_wb_en;
      illegal_o   <= !d_legal;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  // Saturating illegal counter, updated on the accept edge so it lines up with its bundle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      illegal_cnt_o <= '0;
    end else if (accept && !d_legal && (illegal_cnt_o != {CNT_W{1'b1}})) begin
      illegal_cnt_o <= illegal_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: scoreboard of expected bundles from a bench-side decoder.
// A second instance with CNT_W=2 shares the stimulus to observe counter saturation.
module tb_alu_decode_stage;

  typedef struct packed {
    logic [5:0]  alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        src_b_imm;
    logic        use_flag;
    logic        branch;
    logic        wb_en;
    logic        illegal;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] instr_i = 32'b0;
  logic        instr_valid_i = 1'b0;
  logic        out_ready_i = 1'b1;

  logic        instr_ready_o, out_valid_o;
  logic [5:0]  alu_op_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [31:0] imm_o;
  logic        src_b_imm_o, use_flag_o, branch_o, wb_en_o, illegal_o;
  logic [15:0] illegal_cnt_o;

  logic        instr_ready2, out_valid2;
  logic [5:0]  alu_op2;
  logic [4:0]  rs1_2, rs2_2, rd_2;
  logic [31:0] imm2;
  logic        src_b_imm2, use_flag2, branch2, wb_en2, illegal2;
  logic [1:0]  illegal_cnt2;

  always #5 clk = ~clk;

  alu_decode_stage #(.CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .alu_op_o(alu_op_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .imm_o(imm_o),
    .src_b_imm_o(src_b_imm_o), .use_flag_o(use_flag_o), .branch_o(branch_o),
    .wb_en_o(wb_en_o), .illegal_o(illegal_o), .illegal_cnt_o(illegal_cnt_o)
  );

  alu_decode_stage #(.CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready2), .out_valid_o(out_valid2), .out_ready_i(out_ready_i),
    .alu_op_o(alu_op2), .rs1_o(rs1_2), .rs2_o(rs2_2), .rd_o(rd_2), .imm_o(imm2),
    .src_b_imm_o(src_b_imm2), .use_flag_o(use_flag2), .branch_o(branch2),
    .wb_en_o(wb_en2), .illegal_o(illegal2), .illegal_cnt_o(illegal_cnt2)
  );

  bundle_t obs_b;
  assign obs_b = {alu_op_o, rs1_o, rs2_o, rd_o, imm_o, src_b_imm_o, use_flag_o, branch_o, wb_en_o, illegal_o};

  bundle_t     sb[$];
  bundle_t     exp_b;
  bundle_t     snap_b;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic [1:0]  exp_cnt2 = 2'd0;

  // Bench-side reference decoder, written straight from the opcode tables.
  function automatic bundle_t model(input logic [31:0] ins);
    bundle_t    b;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ok;
    f3 = ins[14:12];
    f7 = ins[31:25];
    b = '0;
    b.rs1 = ins[19:15];
    b.rs2 = ins[24:20];
    b.rd  = ins[11:7];
    ok = 1'b0;
    if (ins[6:0] == 7'h33) begin
      b.wb_en = 1'b1;
      ok = 1'b1;
      case ({f7, f3})
        10'b0000000_000: b.alu_op = 6'b011000;
        10'b0000000_001: b.alu_op = 6'b100111;
        10'b0000000_010: begin b.alu_op = 6'b000000; b.use_flag = 1'b1; end
        10'b0000000_011: begin b.alu_op = 6'b000001; b.use_flag = 1'b1; end
        10'b0000000_100: b.alu_op = 6'b101111;
        10'b0000000_101: b.alu_op = 6'b100101;
        10'b0000000_110: b.alu_op = 6'b101110;
        10'b0000000_111: b.alu_op = 6'b010101;
        10'b0100000_000: b.alu_op = 6'b011001;
        10'b0100000_101: b.alu_op = 6'b100100;
        default: ok = 1'b0;
      endcase
    end else if (ins[6:0] == 7'h13) begin
      b.wb_en = 1'b1;
      b.src_b_imm = 1'b1;
      b.imm = {{20{ins[31]}}, ins[31:20]};
      ok = 1'b1;
      case (f3)
        3'd0: b.alu_op = 6'b011000;
        3'd1: begin b.alu_op = 6'b100111; b.imm = {27'b0, ins[24:20]}; ok = (f7 == 7'd0); end
        3'd2: begin b.alu_op = 6'b000000; b.use_flag = 1'b1; end
        3'd3: begin b.alu_op = 6'b000001; b.use_flag = 1'b1; end
        3'd4: b.alu_op = 6'b101111;
        3'd5: begin
          b.imm = {27'b0, ins[24:20]};
          if (f7 == 7'd0) b.alu_op = 6'b100101;
          else if (f7 == 7'b0100000) b.alu_op = 6'b100100;
          else ok = 1'b0;
        end
        3'd6: b.alu_op = 6'b101110;
        default: b.alu_op = 6'b010101;
      endcase
    end else if (ins[6:0] == 7'h63) begin
      b.branch = 1'b1;
      b.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      ok = 1'b1;
      case (f3)
        3'd0: b.alu_op = 6'b001100;
        3'd1: b.alu_op = 6'b001101;
        3'd4: b.alu_op = 6'b000000;
        3'd5: b.alu_op = 6'b001010;
        3'd6: b.alu_op = 6'b000001;
        3'd7: b.alu_op = 6'b001011;
        default: ok = 1'b0;
      endcase
    end
    if (!ok) begin
      b.alu_op = 6'b011000;
      b.imm = 32'd0;
      b.wb_en = 1'b0;
      b.branch = 1'b0;
      b.use_flag = 1'b0;
      b.src_b_imm = 1'b0;
      b.illegal = 1'b1;
    end
    return b;
  endfunction

  // Drive one instruction for one cycle from a negedge; push its expected bundle if it will be accepted.
  task automatic issue(input logic [31:0] ins);
    bundle_t m;
    instr_i = ins;
    instr_valid_i = 1'b1;
    #1;
    if (instr_ready_o) begin
      m = model(ins);
      sb.push_back(m);
      if (m.illegal) begin
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        if (exp_cnt2 != 2'd3) exp_cnt2 = exp_cnt2 + 2'd1;
      end
    end
    @(negedge clk);
    instr_valid_i = 1'b0;
  endtask

  task automatic idle_cycle();
    instr_valid_i = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    out_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (out_valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid_o); else n_pass++;
    n_checks++; if (obs_b !== bundle_t'(0)) $display("FAIL reset_bundle got %h want 0", obs_b); else n_pass++;
    n_checks++; if (illegal_cnt_o !== 16'd0) $display("FAIL reset_cnt got %h want 0", illegal_cnt_o); else n_pass++;
    n_checks++; if (instr_ready_o !== 1'b0) $display("FAIL reset_ready got %b want 0", instr_ready_o); else n_pass++;
    rst_i = 1'b0;
    exp_cnt = 16'd0;
    exp_cnt2 = 2'd0;
    #1;
    n_checks++; if (instr_ready_o !== 1'b1) $display("FAIL ready_after_reset got %b want 1", instr_ready_o); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_add();
    issue(32'h002081B3);
    n_checks++; if (out_valid_o !== 1'b1) $display("FAIL add_valid got %b want 1", out_valid_o); else n_pass++;
    exp_b = sb.pop_front();
    n_checks++; if (obs_b !== exp_b) $display("FAIL add_bundle got %h want %h", obs_b, exp_b); else n_pass++;
    n_checks++; if ({alu_op_o, rs1_o, rs2_o, rd_o, wb_en_o, src_b_imm_o} !== {6'b011000, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0})
      $display("FAIL add_fields got %b want %b", {alu_op_o, rs1_o, rs2_o, rd_o, wb_en_o, src_b_imm_o}, {6'b011000, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0}); else n_pass++;
    idle_cycle();
    n_checks++; if (out_valid_o !== 1'b0) $display("FAIL add_drain got %b want 0", out_valid_o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    issue(32'h407302B3);
    n_checks++; if (instr_ready_o !== 1'b1) $display("FAIL b2b_ready got %b want 1", instr_ready_o); else n_pass++;
    exp_b = sb.pop_front();
    n_checks++; if (obs_b !== exp_b || out_valid_o !== 1'b1) $display("FAIL b2b_sub got %h want %h", obs_b, exp_b); else n_pass++;
    n_checks++; if (alu_op_o !== 6'b011001) $display("FAIL b2b_sub_op got %b want 011001", alu_op_o); else n_pass++;
    issue(32'h40315113);
    exp_b = sb.pop_front();
    n_checks++; if (obs_b !== exp_b || out_valid_o !== 1'b1) $display("FAIL b2b_srai got %h want %h", obs_b, exp_b); else n_pass++;
    n_checks++; if ({alu_op_o, imm_o, src_b_imm_o} !== {6'b100100, 32'h00000003, 1'b1})
      $display("FAIL b2b_srai_fields got %h want %h", {alu_op_o, imm_o, src_b_imm_o}, {6'b100100, 32'h00000003, 1'b1}); else n_pass++;
    idle_cycle();
  endtask

  task automatic test_addi_slt();
    logic [31:0] prog [4];
    prog[0] = 32'hFFF00093;
    prog[1] = 32'h0020A233;
    prog[2] = 32'h00209393;
    prog[3] = 32'h0020F433;
    for (int i = 0; i < 4; i++) begin
      issue(prog[i]);
      exp_b = sb.pop_front();
      n_checks++; if (obs_b !== exp_b || out_valid_o !== 1'b1) $display("FAIL seq%0d got %h want %h", i, obs_b, exp_b); else n_pass++;
      if (i == 0) begin
        n_checks++; if ({alu_op_o, imm_o, src_b_imm_o, rd_o} !== {6'b011000, 32'hFFFFFFFF, 1'b1, 5'd1})
          $display("FAIL addi_fields got %h want %h", {alu_op_o, imm_o, src_b_imm_o, rd_o}, {6'b011000, 32'hFFFFFFFF, 1'b1, 5'd1}); else n_pass++;
      end
      if (i == 1) begin
        n_checks++; if ({alu_op_o, use_flag_o} !== {6'b000000, 1'b1})
          $display("FAIL slt_fields got %b want %b", {alu_op_o, use_flag_o}, {6'b000000, 1'b1}); else n_pass++;
      end
    end
    idle_cycle();
  endtask

  task automatic test_branch();
    issue(32'hFE208EE3);
    exp_b = sb.pop_front();
    n_checks++; if (obs_b !== exp_b) $display("FAIL beq_bundle got %h want %h", obs_b, exp_b); else n_pass++;
    n_checks++; if ({alu_op_o, branch_o, wb_en_o, imm_o} !== {6'b001100, 1'b1, 1'b0, 32'hFFFFFFFC})
      $display("FAIL beq_fields got %h want %h", {alu_op_o, branch_o, wb_en_o, imm_o}, {6'b001100, 1'b1, 1'b0, 32'hFFFFFFFC}); else n_pass++;
    issue(32'hFE20AEE3);
    exp_b = sb.pop_front();
    n_checks++; if (obs_b !== exp_b) $display("FAIL br010_bundle got %h want %h", obs_b, exp_b); else n_pass++;
    n_checks++; if ({illegal_o, branch_o} !== 2'b10) $display("FAIL br010_illegal got %b want 10", {illegal_o, branch_o}); else n_pass++;
    n_checks++; if (illegal_cnt_o !== exp_cnt) $display("FAIL br010_cnt got %h want %h", illegal_cnt_o, exp_cnt); else n_pass++;
    idle_cycle();
  endtask

  task automatic test_backpressure();
    out_ready_i = 1'b0;
    issue(32'h002081B3);
    exp_b = sb.pop_front();
    n_checks++; if (obs_b !== exp_b || out_valid_o !== 1'b1) $display("FAIL bp_first got %h want %h", obs_b, exp_b); else n_pass++;
    snap_b = exp_b;
    instr_i = 32'h407302B3;
    instr_valid_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (instr_ready_o !== 1'b0) $display("FAIL bp_ready%0d got %b want 0", c, instr_ready_o); else n_pass++;
      @(negedge clk);
      n_checks++; if (obs_b !== snap_b || out_valid_o !== 1'b1) $display("FAIL bp_hold%0d got %h want %h", c, obs_b, snap_b); else n_pass++;
    end
    out_ready_i = 1'b1;
    issue(32'h407302B3);
    n_checks++; if (out_valid_o !== 1'b1 || sb.size() != 1) $display("FAIL bp_release got valid %b queue %0d want 1 1", out_valid_o, sb.size()); else n_pass++;
    exp_b = sb.pop_front();
    n_checks++; if (obs_b !== exp_b) $display("FAIL bp_second got %h want %h", obs_b, exp_b); else n_pass++;
    idle_cycle();
    n_checks++; if (out_valid_o !== 1'b0) $display("FAIL bp_once got %b want 0", out_valid_o); else n_pass++;
  endtask

  task automatic test_illegal();
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    exp_cnt = 16'd0;
    exp_cnt2 = 2'd0;
    for (int i = 1; i <= 2; i++) begin
      issue(32'h00000000);
      exp_b = sb.pop_front();
      n_checks++; if (obs_b !== exp_b) $display("FAIL ill%0d_bundle got %h want %h", i, obs_b, exp_b); else n_pass++;
      n_checks++; if ({illegal_o, alu_op_o} !== {1'b1, 6'b011000}) $display("FAIL ill%0d_op got %b want 1011000", i, {illegal_o, alu_op_o}); else n_pass++;
      n_checks++; if (illegal_cnt_o !== 16'(i)) $display("FAIL ill%0d_cnt got %0d want %0d", i, illegal_cnt_o, i); else n_pass++;
    end
    idle_cycle();
  endtask

  task automatic test_reset_held();
    out_ready_i = 1'b0;
    issue(32'h002081B3);
    exp_b = sb.pop_front();
    n_checks++; if (obs_b !== exp_b || out_valid_o !== 1'b1) $display("FAIL rh_bundle got %h want %h", obs_b, exp_b); else n_pass++;
    rst_i = 1'b1;
    out_ready_i = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid_o !== 1'b0) $display("FAIL rh_valid got %b want 0", out_valid_o); else n_pass++;
    n_checks++; if (illegal_cnt_o !== 16'd0) $display("FAIL rh_cnt got %0d want 0", illegal_cnt_o); else n_pass++;
    n_checks++; if (obs_b !== bundle_t'(0)) $display("FAIL rh_cleared got %h want 0", obs_b); else n_pass++;
    rst_i = 1'b0;
    exp_cnt = 16'd0;
    exp_cnt2 = 2'd0;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      issue(32'h00000000 | (32'(i) << 7));
      exp_b = sb.pop_front();
      n_checks++; if (obs_b !== exp_b) $display("FAIL sat%0d_bundle got %h want %h", i, obs_b, exp_b); else n_pass++;
      n_checks++; if (illegal_cnt2 !== exp_cnt2) $display("FAIL sat%0d_cnt2 got %0d want %0d", i, illegal_cnt2, exp_cnt2); else n_pass++;
    end
    n_checks++; if (illegal_cnt2 !== 2'd3) $display("FAIL sat_final2 got %0d want 3", illegal_cnt2); else n_pass++;
    n_checks++; if (illegal_cnt_o !== 16'd5) $display("FAIL sat_final16 got %0d want 5", illegal_cnt_o); else n_pass++;
    idle_cycle();
    n_checks++; if (sb.size() != 0) $display("FAIL sb_leftover got %0d want 0", sb.size()); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_addi_slt();
    test_branch();
    test_backpressure();
    test_illegal();
    test_reset_held();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
